// File: rtl/tc_timer_if.sv
// Bus-side signals of the countdown timer: word offset, qualified write
// strobe, store byte enables and data, read data and interrupt request.
interface tc_timer_if;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  byteEn;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (
        output addr, we, byteEn, din,
        input  dout, irq
    );

    modport slave (
        input  addr, we, byteEn, din,
        output dout, irq
    );
endinterface

// File: rtl/tc_timer.sv
// Memory-mapped countdown timer. CTRL (EN, MODE, IM), PRESET and a read-only
// COUNT. A small FSM loads PRESET, counts down to zero and raises a flag that
// is gated by IM to form the interrupt request. Any accepted CTRL/PRESET write
// restarts the FSM from IDLE and drops the flag.
module tc_timer (
    input  logic      clk,
    input  logic      reset,
    tc_timer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;
    localparam logic [1:0] MODE_AUTO = 2'd1;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;

    logic wr_ok;
    logic wr_ctrl;
    logic wr_preset;

    // Only full-word stores are honoured; partial stores are dropped silently.
    assign wr_ok     = bus.we && (bus.byteEn == 4'b1111);
    assign wr_ctrl   = wr_ok && (bus.addr == A_CTRL);
    assign wr_preset = wr_ok && (bus.addr == A_PRESET);

    // State register with asynchronous clear of every register.
    // NOTE: clocked state uses non-blocking assignments so all registers
    // update together from the values they held before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'h0;
            preset_q <= 32'h0;
            count_q  <= 32'h0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
        end
    end

    // Next-state logic: software writes take priority over the countdown FSM.
    always_comb begin
        // NOTE: every output gets a hold value first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;

        if (wr_ctrl || wr_preset) begin
            if (wr_ctrl) begin
                ctrl_d = bus.din[3:0];
            end
            if (wr_preset) begin
                preset_d = bus.din;
            end
            state_d = S_IDLE;
            flag_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ctrl_q[0]) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_q[0]) begin
                        state_d = S_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        // Clamp at zero so a zero preset behaves like one.
                        count_d = 32'd0;
                        flag_d  = 1'b1;
                        state_d = S_INT;
                    end
                end
                S_INT: begin
                    if (ctrl_q[2:1] == MODE_AUTO) begin
                        // Auto-reload: EN stays set, so IDLE re-arms at once.
                        flag_d = 1'b0;
                    end else begin
                        // One-shot: disarm; flag holds until software acts.
                        ctrl_d[0] = 1'b0;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Read mux, combinational on the word offset.
    always_comb begin
        bus.dout = 32'h0;
        case (bus.addr)
            A_CTRL:   bus.dout = {28'h0, ctrl_q};
            A_PRESET: bus.dout = preset_q;
            A_COUNT:  bus.dout = count_q;
            default:  bus.dout = 32'h0;
        endcase
    end

    assign bus.irq = flag_q & ctrl_q[3];
endmodule
